// File: rtl/axi_addr_ch_tx_q.sv
// axi_addr_ch_tx_q: buffered AXI4 address-channel (AR/AW) transmitter.
//
// Translated requests enter a DEPTH-entry FIFO (push = t_done & t_ready).
// A splitter drains the FIFO into one registered address channel. With
// SPLIT_4K=1, INCR bursts that cross a 4 KB page are issued as several
// legal bursts that carry identical attributes.
//
// Ports:
//   tx_clk, reset_        clock, synchronous active-low reset
//   in_* / phy_addr       request fields from the translator
//   t_done / t_ready      request valid / FIFO can accept
//   out_* / out_valid     registered address channel towards the slave
//   in_ready              slave ready
//   count                 FIFO occupancy (the output register is not counted)
//   busy                  out_valid | (count != 0)
module axi_addr_ch_tx_q #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int USER_W   = 2,
  parameter int DEPTH    = 4,
  parameter int SPLIT_4K = 1
) (
  input  logic                       tx_clk,
  input  logic                       reset_,
  input  logic [ID_W-1:0]            in_id,
  input  logic [7:0]                 in_len,
  input  logic [2:0]                 in_size,
  input  logic [1:0]                 in_burst,
  input  logic [2:0]                 in_prot,
  input  logic [3:0]                 in_cache,
  input  logic [USER_W-1:0]          in_user,
  input  logic                       in_lock,
  input  logic [ADDR_W-1:0]          phy_addr,
  input  logic                       t_done,
  output logic                       t_ready,
  output logic [ID_W-1:0]            out_id,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [7:0]                 out_len,
  output logic [2:0]                 out_size,
  output logic [1:0]                 out_burst,
  output logic [2:0]                 out_prot,
  output logic [3:0]                 out_cache,
  output logic [USER_W-1:0]          out_user,
  output logic                       out_lock,
  output logic                       out_valid,
  input  logic                       in_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [2:0]        prot;
    logic [3:0]        cache;
    logic [USER_W-1:0] user;
    logic              lock;
  } req_t;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  // Beats of the piece starting at 'addr_lo' given 'beats' still to send.
  // Only INCR bursts are clipped to the end of the current 4 KB page.
  function automatic logic [8:0] piece_beats(input logic [11:0] addr_lo,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst,
                                             input logic [8:0]  beats);
    logic [12:0] a_low;
    logic [12:0] room;
    a_low = {1'b0, addr_lo} & ~((13'd1 << size) - 13'd1);
    room  = (13'd4096 - a_low) >> size;
    if ((SPLIT_4K != 0) && (burst == 2'b01) && ({4'd0, beats} > room))
      piece_beats = room[8:0];
    else
      piece_beats = beats;
  endfunction

  req_t              fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  req_t              out_q, out_d;
  logic [8:0]        rem_q, rem_d;

  req_t              in_req, head;
  logic              push, pop, wr, load, hs;
  logic [8:0]        beats, pb, lenm;
  logic [ADDR_W-1:0] naddr;

  always_comb begin
    in_req       = '0;
    in_req.id    = in_id;
    in_req.addr  = phy_addr;
    in_req.len   = in_len;
    in_req.size  = in_size;
    in_req.burst = in_burst;
    in_req.prot  = in_prot;
    in_req.cache = in_cache;
    in_req.user  = in_user;
    in_req.lock  = in_lock;
  end

  assign t_ready = reset_ & (count_q < CNT_W'(DEPTH));
  assign push    = t_done & t_ready;
  assign hs      = (state_q == S_SEND) & in_ready;

  // An idle channel with an empty FIFO takes the request straight from the
  // input, so out_valid rises on the cycle after t_done.
  assign head = (count_q != '0) ? fifo_q[rd_ptr_q] : in_req;
  assign load = ((state_q == S_IDLE) && ((count_q != '0) || push)) ||
                (hs && (rem_q == 9'd0) && (count_q != '0));
  assign pop  = load && (count_q != '0);
  assign wr   = push && !(load && (count_q == '0));

  // Continuation pieces always start on the next 4 KB page.
  assign naddr = {out_q.addr[ADDR_W-1:12] + (ADDR_W-12)'(1), 12'h000};

  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    if (wr && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !wr)
      count_d = count_q - CNT_W'(1);
    else
      count_d = count_q;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    beats   = 9'd0;
    pb      = 9'd0;
    lenm    = 9'd0;
    if (load) begin
      beats     = {1'b0, head.len} + 9'd1;
      pb        = piece_beats(head.addr[11:0], head.size, head.burst, beats);
      lenm      = pb - 9'd1;
      out_d     = head;
      out_d.len = lenm[7:0];
      rem_d     = beats - pb;
      state_d   = S_SEND;
    end else if (hs && (rem_q != 9'd0)) begin
      pb         = piece_beats(naddr[11:0], out_q.size, out_q.burst, rem_q);
      lenm       = pb - 9'd1;
      out_d.addr = naddr;
      out_d.len  = lenm[7:0];
      rem_d      = rem_q - pb;
    end else if (hs) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!reset_) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only; validity is tracked by the pointers/count.
  always_ff @(posedge tx_clk) begin
    if (wr) fifo_q[wr_ptr_q] <= in_req;
  end

  assign out_id    = out_q.id;
  assign out_addr  = out_q.addr;
  assign out_len   = out_q.len;
  assign out_size  = out_q.size;
  assign out_burst = out_q.burst;
  assign out_prot  = out_q.prot;
  assign out_cache = out_q.cache;
  assign out_user  = out_q.user;
  assign out_lock  = out_q.lock;
  assign out_valid = (state_q == S_SEND);
  assign count     = count_q;
  assign busy      = out_valid | (count_q != '0);

endmodule
